// File: rtl/timer_array_if.sv
// Peripheral bus bundle for timer_array: active-low select/strobe/ready,
// word address, 32-bit write data in and registered read data out.
interface timer_array_if;
  logic        cs_;
  logic        as_;
  logic        rw;
  logic [29:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rdy_;

  modport master (
    output cs_, as_, rw, addr, wr_data,
    input  rd_data, rdy_
  );

  modport slave (
    input  cs_, as_, rw, addr, wr_data,
    output rd_data, rdy_
  );
endinterface

// File: rtl/timer_array.sv
// Multi-channel bus-slave timer: per channel a prescaled up-counter with compare,
// one-shot/periodic mode, interrupt enable and write-1-to-clear status.
module timer_array #(
  parameter int NUM_CH     = 4,
  parameter int CNT_W      = 32,
  parameter int PRESCALE_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  timer_array_if.slave      bus,
  output logic [NUM_CH-1:0] irq_vec,
  output logic              irq
);
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_INTR = 2'd1;
  localparam logic [1:0] REG_EXPR = 2'd2;
  localparam logic [1:0] REG_CNT  = 2'd3;

  logic        access;
  logic        wr_access;
  logic        rd_access;
  logic [2:0]  ch_sel;
  logic [1:0]  reg_sel;
  logic [31:0] ch_rd_data [8];
  logic [31:0] rd_data_reg, rd_data_next;
  logic        rdy_reg, rdy_next;
  logic        irq_reg, irq_next;
  logic        unused_bits;

  assign access    = (bus.cs_ == ENABLE_) && (bus.as_ == ENABLE_);
  assign wr_access = access && (bus.rw == WRITE);
  assign rd_access = access && (bus.rw == READ);
  assign ch_sel    = bus.addr[4:2];
  assign reg_sel   = bus.addr[1:0];
  assign unused_bits = ^{bus.addr[29:5], bus.wr_data};

  // Eight decode slots so any 3-bit channel index resolves; absent channels read 0.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_slot
      if (gi < NUM_CH) begin : g_ch
        logic                  start_reg, start_next;
        logic                  mode_reg, mode_next;
        logic                  irq_en_reg, irq_en_next;
        logic                  status_reg, status_next;
        logic [PRESCALE_W-1:0] prescale_reg, prescale_next;
        logic [PRESCALE_W-1:0] pc_reg, pc_next;
        logic [CNT_W-1:0]      cnt_reg, cnt_next;
        logic [CNT_W-1:0]      expr_reg, expr_next;
        logic                  sel, ctrl_wr, intr_wr, expr_wr, cnt_wr;
        logic                  tick, expire;
        logic [31:0]           ctrl_word;

        assign sel     = wr_access && (ch_sel == 3'(gi));
        assign ctrl_wr = sel && (reg_sel == REG_CTRL);
        assign intr_wr = sel && (reg_sel == REG_INTR);
        assign expr_wr = sel && (reg_sel == REG_EXPR);
        assign cnt_wr  = sel && (reg_sel == REG_CNT);

        assign tick   = start_reg && (pc_reg == prescale_reg);
        assign expire = tick && (cnt_reg == expr_reg);

        always_comb begin
          start_next    = start_reg;
          mode_next     = mode_reg;
          irq_en_next   = irq_en_reg;
          prescale_next = prescale_reg;
          status_next   = status_reg;
          expr_next     = expr_reg;
          cnt_next      = cnt_reg;

          if (ctrl_wr) begin
            start_next    = bus.wr_data[0];
            mode_next     = bus.wr_data[1];
            irq_en_next   = bus.wr_data[2];
            prescale_next = bus.wr_data[8 +: PRESCALE_W];
          end else if (expire && !mode_reg) begin
            start_next = 1'b0;
          end

          pc_next = (ctrl_wr || !start_reg || tick) ? '0 : pc_reg + PRESCALE_W'(1);

          // A CNT write overrides only the counter; the expiry still sets status.
          if (cnt_wr)
            cnt_next = bus.wr_data[CNT_W-1:0];
          else if (expire)
            cnt_next = '0;
          else if (tick)
            cnt_next = cnt_reg + CNT_W'(1);

          if (expire)
            status_next = 1'b1;
          else if (intr_wr && bus.wr_data[0])
            status_next = 1'b0;

          if (expr_wr)
            expr_next = bus.wr_data[CNT_W-1:0];
        end

        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            start_reg    <= 1'b0;
            mode_reg     <= 1'b0;
            irq_en_reg   <= 1'b0;
            status_reg   <= 1'b0;
            prescale_reg <= '0;
            pc_reg       <= '0;
            cnt_reg      <= '0;
            expr_reg     <= '0;
          end else begin
            start_reg    <= start_next;
            mode_reg     <= mode_next;
            irq_en_reg   <= irq_en_next;
            status_reg   <= status_next;
            prescale_reg <= prescale_next;
            pc_reg       <= pc_next;
            cnt_reg      <= cnt_next;
            expr_reg     <= expr_next;
          end
        end

        always_comb begin
          ctrl_word                   = '0;
          ctrl_word[0]                = start_reg;
          ctrl_word[1]                = mode_reg;
          ctrl_word[2]                = irq_en_reg;
          ctrl_word[8 +: PRESCALE_W]  = prescale_reg;
        end

        assign ch_rd_data[gi] = (reg_sel == REG_CTRL) ? ctrl_word :
                                (reg_sel == REG_INTR) ? 32'(status_reg) :
                                (reg_sel == REG_EXPR) ? 32'(expr_reg) :
                                                        32'(cnt_reg);
        assign irq_vec[gi] = status_reg & irq_en_reg;
      end else begin : g_absent
        assign ch_rd_data[gi] = '0;
      end
    end
  endgenerate

  assign rd_data_next = rd_access ? ch_rd_data[ch_sel] : '0;
  assign rdy_next     = access ? ENABLE_ : DISABLE_;
  assign irq_next     = |irq_vec;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_reg <= '0;
      rdy_reg     <= DISABLE_;
      irq_reg     <= 1'b0;
    end else begin
      rd_data_reg <= rd_data_next;
      rdy_reg     <= rdy_next;
      irq_reg     <= irq_next;
    end
  end

  assign bus.rd_data = rd_data_reg;
  assign bus.rdy_    = rdy_reg;
  assign irq         = irq_reg;
endmodule
